imm_gen_stage: RTL and testbench

Registered, parametrised immediate generator for the decode stage. It accepts a raw instruction word plus a 3-bit format select over a valid/ready handshake. It emits the sign- or zero-extended immediate one cycle later, with a 2-entry skid buffer so that backpressure never drops data. It generalises the combinational extender to XLEN 32/64, adds shamt/CSR-zimm formats and an illegal-format flag, and passes a sideband tag (e.g. PC) through.

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_extend.sv | 41 ++++
 rtl/imm_gen_stage.sv | 131 +++++++++++++
 tb/tb_imm_gen_stage.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage: format encodings and
// the legal-XLEN check used at elaboration.
package imm_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_RSVD  = 3'b111;

    function automatic bit imm_xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extend.sv
// Combinational format mux: picks the immediate field for imm_src out of the
// instruction word and extends it to XLEN; reserved select flags illegal.
module imm_extend
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] w_u_field;
    logic        unused_opcode;

    assign w_u_field     = {instr[31:12], 12'b0};
    assign unused_opcode = ^instr[6:0];

    // Signed size casts do the sign extension; unsigned casts zero-extend.
    always_comb begin
        imm     = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I:     imm = XLEN'($signed(instr[31:20]));
            IMM_S:     imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            IMM_B:     imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                            instr[11:8], 1'b0}));
            IMM_J:     imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                            instr[30:21], 1'b0}));
            IMM_U:     imm = XLEN'($signed(w_u_field));
            IMM_SHAMT: imm = (XLEN == 32) ? XLEN'(instr[24:20]) : XLEN'(instr[25:20]);
            IMM_ZIMM:  imm = XLEN'(instr[19:15]);
            default: begin
                imm     = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer on a valid/ready
// handshake. Define IMM_GEN_STATS_EN to add pop/illegal-pop counters.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ILEN-1:0]  instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
`ifdef IMM_GEN_STATS_EN
    ,
    output logic [31:0]      stat_count,
    output logic [15:0]      stat_illegal
`endif
);

    if (!imm_xlen_legal(XLEN)) begin : g_xlen_check
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  w_imm;
    logic             w_illegal;
    logic             w_accept;
    logic             w_pop;
    logic             w_to_main;
    logic             w_to_skid;
    logic             w_main_valid_next;
    logic             w_skid_valid_next;

    logic             r_in_ready;
    logic             r_main_valid;
    logic [XLEN-1:0]  r_main_imm;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_main_ill;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_skid_ill;

    imm_extend #(.XLEN(XLEN)) u_extend (
        .instr   (instr[31:0]),
        .imm_src (imm_src),
        .imm     (w_imm),
        .illegal (w_illegal)
    );

    // in_ready is registered; the rstn term only forces it low while reset is held.
    assign in_ready = r_in_ready && rstn;

    assign w_accept  = in_valid && r_in_ready && en;
    assign w_pop     = r_main_valid && out_ready && en;
    assign w_to_main = w_accept && (!r_main_valid || (w_pop && !r_skid_valid));
    assign w_to_skid = w_accept && !w_to_main;

    assign w_main_valid_next = !flush && (w_to_main || (r_main_valid && !w_pop)
                                          || (w_pop && r_skid_valid));
    assign w_skid_valid_next = !flush && ((r_skid_valid && !w_pop) || w_to_skid);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_in_ready   <= 1'b0;
            r_main_valid <= 1'b0;
            r_main_imm   <= '0;
            r_main_tag   <= '0;
            r_main_ill   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_tag   <= '0;
            r_skid_ill   <= 1'b0;
        end else begin
            r_in_ready   <= en && !w_skid_valid_next;
            r_main_valid <= w_main_valid_next;
            r_skid_valid <= w_skid_valid_next;
            if (w_pop && r_skid_valid) begin
                r_main_imm <= r_skid_imm;
                r_main_tag <= r_skid_tag;
                r_main_ill <= r_skid_ill;
            end else if (w_to_main) begin
                r_main_imm <= w_imm;
                r_main_tag <= in_tag;
                r_main_ill <= w_illegal;
            end
            if (w_to_skid) begin
                r_skid_imm <= w_imm;
                r_skid_tag <= in_tag;
                r_skid_ill <= w_illegal;
            end
        end
    end

    assign out_valid   = r_main_valid;
    assign imm         = r_main_imm;
    assign out_tag     = r_main_tag;
    assign out_illegal = r_main_ill;

`ifdef IMM_GEN_STATS_EN
    logic [31:0] r_stat_count;
    logic [15:0] r_stat_illegal;

    // A pop cancelled by flush never reached downstream, so it is not counted.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stat_count   <= '0;
            r_stat_illegal <= '0;
        end else if (w_pop && !flush) begin
            r_stat_count <= r_stat_count + 32'd1;
            if (r_main_ill) begin
                r_stat_illegal <= r_stat_illegal + 16'd1;
            end
        end
    end

    assign stat_count   = r_stat_count;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: one XLEN=32 and one XLEN=64 instance
// share stimulus; expected entries come from a field-arithmetic reference model.
module tb_imm_gen_stage;

    typedef struct {
        logic [63:0] imm;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn, en, flush, in_valid, out_ready;
    logic [31:0] instr, in_tag;
    logic [2:0]  imm_src;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tag32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;
`ifdef IMM_GEN_STATS_EN
    logic [31:0] stat_count32, stat_count64;
    logic [15:0] stat_illegal32, stat_illegal64;
    int          pops32 = 0;
    int          ill_pops32 = 0;
`endif

    int checks = 0;
    int errors = 0;
    exp_t q32[$];
    exp_t q64[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .ILEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rstn(rstn), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .instr(instr),
        .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .imm(imm32), .out_tag(tag32), .out_illegal(ill32)
`ifdef IMM_GEN_STATS_EN
        , .stat_count(stat_count32), .stat_illegal(stat_illegal32)
`endif
    );

    imm_gen_stage #(.XLEN(64), .ILEN(32), .TAG_W(32)) dut64 (
        .clk(clk), .rstn(rstn), .en(en), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
        .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .imm(imm64), .out_tag(tag64), .out_illegal(ill64)
`ifdef IMM_GEN_STATS_EN
        , .stat_count(stat_count64), .stat_illegal(stat_illegal64)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Immediate assembled from the format's bit-field layout, then sign-extended
    // arithmetically by subtracting 2^width when the top field bit is set.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [2:0] src,
                                       input logic [31:0] tag, input int xlen);
        exp_t e;
        longint unsigned w, v;
        int bits;
        bit sx;
        w = 64'(ins);
        v = 0; bits = 1; sx = 0;
        e.ill = 1'b0;
        case (src)
            3'd0: begin v = w >> 20; bits = 12; sx = 1; end
            3'd1: begin v = ((w >> 25) << 5) | ((w >> 7) & 31); bits = 12; sx = 1; end
            3'd2: begin
                v = (((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11)
                  | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
                bits = 13; sx = 1;
            end
            3'd3: begin
                v = (((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12)
                  | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
                bits = 21; sx = 1;
            end
            3'd4: begin v = w & 64'hFFFF_F000; bits = 32; sx = 1; end
            3'd5: v = (w >> 20) & ((xlen == 32) ? 64'd31 : 64'd63);
            3'd6: v = (w >> 15) & 31;
            default: begin v = 0; e.ill = 1'b1; end
        endcase
        if (sx && (((v >> (bits - 1)) & 1) == 1)) v = v - (64'd1 << bits);
        if (xlen == 32) v = v & 64'hFFFF_FFFF;
        e.imm = v;
        e.tag = tag;
        return e;
    endfunction

    // Stimulus side: every accepted input pushes its expected result.
    always @(posedge clk) begin
        if (rstn && en && !flush && in_valid) begin
            if (in_ready32) q32.push_back(ref_model(instr, imm_src, in_tag, 32));
            if (in_ready64) q64.push_back(ref_model(instr, imm_src, in_tag, 64));
        end
    end

    // Monitors: the model queue is the buffer content; a pop happens at the
    // coming edge when the model holds an entry and downstream is ready.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            q32.delete();
        end else begin
            chk("valid32", 64'(out_valid32), 64'(q32.size() != 0));
            if (flush) begin
                q32.delete();
            end else if (en && out_ready && q32.size() != 0) begin
                e = q32.pop_front();
                chk("imm32", 64'(imm32), e.imm);
                chk("tag32", 64'(tag32), 64'(e.tag));
                chk("ill32", 64'(ill32), 64'(e.ill));
`ifdef IMM_GEN_STATS_EN
                pops32++;
                if (e.ill) ill_pops32++;
`endif
                $display("pop tag=%h imm32=%h ill=%0b", tag32, imm32, ill32);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            q64.delete();
        end else begin
            chk("valid64", 64'(out_valid64), 64'(q64.size() != 0));
            if (flush) begin
                q64.delete();
            end else if (en && out_ready && q64.size() != 0) begin
                e = q64.pop_front();
                chk("imm64", imm64, e.imm);
                chk("tag64", 64'(tag64), 64'(e.tag));
                chk("ill64", 64'(ill64), 64'(e.ill));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [2:0] src, input logic [31:0] tag);
        in_valid = 1'b1;
        instr    = ins;
        imm_src  = src;
        in_tag   = tag;
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        flush     = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 30) begin
            step();
            n++;
        end
        step();
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain64", 64'(q64.size()), 64'd0);
    endtask

    logic [31:0] dir_instr[10] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h001000EF,
                                   32'h123450B7, 32'h12345678, 32'h80000037, 32'h03F01013,
                                   32'h000FD073, 32'h7FFFF0B7};
    logic [2:0]  dir_src[10]   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7, 3'd4, 3'd5, 3'd6, 3'd4};

    initial begin
        int n, cyc;
        logic rdy;
        rstn = 1'b0; en = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; imm_src = '0; in_tag = '0;

        repeat (3) step();
        chk("rst_valid", 64'(out_valid32), 64'd0);
        chk("rst_imm32", 64'(imm32), 64'd0);
        chk("rst_imm64", imm64, 64'd0);
        chk("rst_tag", 64'(tag32), 64'd0);
        chk("rst_ill", 64'(ill32), 64'd0);
        chk("rst_ready", 64'(in_ready32), 64'd0);
        rstn = 1'b1; en = 1'b1; out_ready = 1'b1;
        #1;
        chk("rel_ready0", 64'(in_ready32), 64'd0);
        step();
        chk("rel_ready1", 64'(in_ready32), 64'd1);

        // Directed formats at full throughput.
        for (int i = 0; i < 10; i++) begin
            drive(dir_instr[i], dir_src[i], 32'h1000 + i);
            step();
        end
        drain();

        // Backpressure: two accepts fill the buffer, then in_ready falls.
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'd0, 32'd100);
        step();
        chk("bp_ready_a", 64'(in_ready32), 64'd1);
        drive(32'hFE20AE23, 3'd1, 32'd101);
        step();
        chk("bp_full", 64'(in_ready32), 64'd0);
        chk("bp_full64", 64'(in_ready64), 64'd0);
        drive(32'hFE000CE3, 3'd2, 32'd102);
        step();
        chk("bp_hold", 64'(in_ready32), 64'd0);
        out_ready = 1'b1;
        n = 2; cyc = 0;
        while (n < 4 && cyc < 20) begin
            drive((n == 2) ? 32'hFE000CE3 : 32'h001000EF, (n == 2) ? 3'd2 : 3'd3, 32'd100 + n);
            rdy = in_ready32;
            step();
            if (rdy) n++;
            cyc++;
        end
        chk("bp_done", 64'(n), 64'd4);
        chk("bp_cycles", 64'(cyc), 64'd3);
        drain();

        // Flush with both entries full and a concurrent input.
        out_ready = 1'b0;
        drive(32'h123450B7, 3'd4, 32'd200);
        step();
        drive(32'h03F01013, 3'd5, 32'd201);
        step();
        drive(32'h000FD073, 3'd6, 32'd202);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid32", 64'(out_valid32), 64'd0);
        chk("fl_valid64", 64'(out_valid64), 64'd0);
        chk("fl_ready", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // Randomised traffic with stalls, enable drops and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive($urandom, 3'($urandom_range(0, 7)), $urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            en        = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        drain();

        // Reset for one cycle mid-stream.
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'd0, 32'd300);
        step();
        rstn = 1'b0;
        #1;
        chk("mr_ready_lo", 64'(in_ready32), 64'd0);
        step();
        rstn = 1'b1; in_valid = 1'b0;
        chk("mr_valid", 64'(out_valid32), 64'd0);
        chk("mr_imm", 64'(imm32), 64'd0);
        chk("mr_tag", 64'(tag32), 64'd0);
        chk("mr_ill", 64'(ill32), 64'd0);
        chk("mr_ready0", 64'(in_ready32), 64'd0);
`ifdef IMM_GEN_STATS_EN
        chk("mr_stat_cnt", 64'(stat_count32), 64'd0);
        chk("mr_stat_ill", 64'(stat_illegal32), 64'd0);
        pops32 = 0;
        ill_pops32 = 0;
`endif
        step();
        chk("mr_ready1", 64'(in_ready32), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive($urandom, 3'(i), 32'd400 + i);
            step();
        end
        drain();
`ifdef IMM_GEN_STATS_EN
        chk("stat_cnt", 64'(stat_count32), 64'(pops32));
        chk("stat_ill", 64'(stat_illegal32), 64'(ill_pops32));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
